// File: rtl/rx_pkg.sv
// Shared width defaults and derived packet width for the node-side receiver.
package rx_pkg;
  localparam int DEF_DATA_WIDTH = 2;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_ID_WIDTH   = 2;
  localparam int DATA_WIDTH     = DEF_DATA_WIDTH;
  localparam int ADDR_WIDTH     = DEF_ADDR_WIDTH;
  localparam int ID_WIDTH       = DEF_ID_WIDTH;
  localparam int PKT_WIDTH      = DATA_WIDTH + ADDR_WIDTH + ID_WIDTH;
endpackage

// File: rtl/receiver_if.sv
// Router-to-node packet bus plus the local processor read port.
interface receiver_if
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
);
  logic [DATA_WIDTH+ADDR_WIDTH+ID_WIDTH-1:0] rx_in;
  logic [ID_WIDTH-1:0]                       id;
  logic                                      rtr_write_enable;
  logic [ADDR_WIDTH-1:0]                     rx_addr;
  logic [1:0]                                flag_res;
  logic [DATA_WIDTH-1:0]                     data_out;

  modport master (
    output rx_in, id, rtr_write_enable, rx_addr,
    input  flag_res, data_out
  );

  modport slave (
    input  rx_in, id, rtr_write_enable, rx_addr,
    output flag_res, data_out
  );
endinterface

// File: rtl/rx_buffer.sv
// Receive register file: one synchronous write port, one combinational read
// port, and a per-entry valid bit that only reset clears.
module rx_buffer
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (we) begin
      mem[waddr]   <= wdata;
      valid[waddr] <= 1'b1;
    end
  end

  // No write-to-read bypass: a same-address write shows up after the edge.
  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];
endmodule

// File: rtl/receiver.sv
// Node receiver: decodes the packet word, accepts packets addressed to this
// node into rx_buffer, and reports a one-cycle accept pulse.
module receiver
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_WIDTH+ADDR_WIDTH+ID_WIDTH-1:0] rx_in,
  input  logic [ID_WIDTH-1:0]                       id,
  input  logic                                      rtr_write_enable,
  input  logic [ADDR_WIDTH-1:0]                     rx_addr,
  output logic [1:0]                                flag_res,
  output logic [DATA_WIDTH-1:0]                     data_out
);
  localparam int ADDR_LSB = ID_WIDTH;
  localparam int DATA_LSB = ID_WIDTH + ADDR_WIDTH;

  logic [ID_WIDTH-1:0]   dest_id;
  logic [ADDR_WIDTH-1:0] pkt_addr;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic                  accept;
  logic                  accept_pulse;
  logic                  entry_valid;

  assign dest_id  = rx_in[ID_WIDTH-1:0];
  assign pkt_addr = rx_in[ADDR_LSB +: ADDR_WIDTH];
  assign pkt_data = rx_in[DATA_LSB +: DATA_WIDTH];
  assign accept   = rtr_write_enable && (dest_id == id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_pulse <= 1'b0;
    end else begin
      accept_pulse <= accept;
    end
  end

  rx_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_buffer (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .waddr  (pkt_addr),
    .wdata  (pkt_data),
    .raddr  (rx_addr),
    .rdata  (data_out),
    .rvalid (entry_valid)
  );

  assign flag_res = {accept_pulse, entry_valid};
endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed scenarios plus randomized traffic
// against an array-based model of the receive buffer.
module tb_receiver;
  import rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  receiver_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  receiver #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_in            (bus.rx_in),
    .id               (bus.id),
    .rtr_write_enable (bus.rtr_write_enable),
    .rx_addr          (bus.rx_addr),
    .flag_res         (bus.flag_res),
    .data_out         (bus.data_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by buffer address.
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  int m_data  [DEPTH];
  bit m_valid [DEPTH];
  bit m_pulse;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i]  = 0;
      m_valid[i] = 0;
    end
    m_pulse = 0;
  endfunction

  function automatic void model_edge(bit we, int pkt, int node);
    int dst, adr, dat;
    dst = pkt % (2 ** ID_WIDTH);
    adr = (pkt / (2 ** ID_WIDTH)) % DEPTH;
    dat = pkt / (2 ** (ID_WIDTH + ADDR_WIDTH));
    m_pulse = we && (dst == node);
    if (m_pulse) begin
      m_data[adr]  = dat;
      m_valid[adr] = 1;
    end
  endfunction

  function automatic logic [DATA_WIDTH+1:0] model_view(int a);
    logic [DATA_WIDTH+1:0] v;
    v = {m_pulse, m_valid[a], DATA_WIDTH'(m_data[a])};
    return v;
  endfunction

  task automatic tick();
    if (!rst) model_edge(bus.rtr_write_enable, int'(bus.rx_in), int'(bus.id));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.id = 2'b01; bus.rx_addr = 2'b00; bus.rx_in = 6'b001101;
    bus.rtr_write_enable = 1'b0;
    rst = 1'b1;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({bus.flag_res, bus.data_out} !== 4'b0000) begin
        $display("FAIL reset_hold cyc%0d got flag=%b data=%b want flag=00 data=00",
                 c, bus.flag_res, bus.data_out);
        miscompares++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_accept();
    bus.rtr_write_enable = 1'b1;
    tick();
    bus.rtr_write_enable = 1'b0;
    bus.rx_addr = 2'b11; #1;
    vectors++;
    if ({bus.flag_res, bus.data_out} !== 4'b1100) begin
      $display("FAIL accept_hit got flag=%b data=%b want flag=11 data=00", bus.flag_res, bus.data_out);
      miscompares++;
    end
    bus.rx_addr = 2'b00; #1;
    vectors++;
    if (bus.flag_res !== 2'b10) begin
      $display("FAIL accept_other got flag=%b want 10", bus.flag_res);
      miscompares++;
    end
    tick();
    bus.rx_addr = 2'b11; #1;
    vectors++;
    if (bus.flag_res !== 2'b01) begin
      $display("FAIL accept_after got flag=%b want 01", bus.flag_res);
      miscompares++;
    end
    bus.rx_addr = 2'b00; #1;
    vectors++;
    if (bus.flag_res !== 2'b00) begin
      $display("FAIL accept_after_other got flag=%b want 00", bus.flag_res);
      miscompares++;
    end
  endtask

  task automatic test_mismatch();
    bus.rx_in = 6'b100110; bus.id = 2'b01; bus.rtr_write_enable = 1'b1;
    bus.rx_addr = 2'b01;
    tick();
    bus.rtr_write_enable = 1'b0;
    vectors++;
    if ({bus.flag_res, bus.data_out} !== 4'b0000) begin
      $display("FAIL mismatch got flag=%b data=%b want flag=00 data=00", bus.flag_res, bus.data_out);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pkts [2];
    logic [3:0] want [3];
    pkts[0] = 6'b100101; pkts[1] = 6'b110101;
    want[0] = 4'b1110; want[1] = 4'b1111; want[2] = 4'b0111;
    bus.rx_addr = 2'b01;
    for (int c = 0; c < 3; c++) begin
      bus.rtr_write_enable = (c < 2);
      if (c < 2) bus.rx_in = pkts[c];
      tick();
      vectors++;
      if ({bus.flag_res, bus.data_out} !== want[c]) begin
        $display("FAIL back_to_back cyc%0d got flag=%b data=%b want %b",
                 c, bus.flag_res, bus.data_out, want[c]);
        miscompares++;
      end
    end
    bus.rtr_write_enable = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.id = 2'b10;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rx_in = {2'(a + 1), 2'(a), 2'b10};
      bus.rtr_write_enable = 1'b1;
      tick();
    end
    bus.rtr_write_enable = 1'b0;
    bus.rx_addr = 2'b00; #1;
    vectors++;
    if ({bus.flag_res, bus.data_out} !== 4'b1101) begin
      $display("FAIL filled_entry0 got flag=%b data=%b want flag=11 data=01", bus.flag_res, bus.data_out);
      miscompares++;
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rx_addr = 2'(a); #1;
      vectors++;
      if ({bus.flag_res, bus.data_out} !== 4'b0000) begin
        $display("FAIL async_reset addr%0d got flag=%b data=%b want 00/00", a, bus.flag_res, bus.data_out);
        miscompares++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rx_addr = 2'(a); #1;
      vectors++;
      if ({bus.flag_res, bus.data_out} !== 4'b0000) begin
        $display("FAIL post_reset addr%0d got flag=%b data=%b want 00/00", a, bus.flag_res, bus.data_out);
        miscompares++;
      end
    end
    // Strobe on the first edge after release must land.
    bus.rx_in = 6'b111010; bus.rtr_write_enable = 1'b1;
    tick();
    bus.rtr_write_enable = 1'b0;
    bus.rx_addr = 2'b10; #1;
    vectors++;
    if ({bus.flag_res, bus.data_out} !== 4'b1111) begin
      $display("FAIL first_edge_accept got flag=%b data=%b want flag=11 data=11", bus.flag_res, bus.data_out);
      miscompares++;
    end
  endtask

  task automatic test_comb_read();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rx_in = {2'($urandom_range(0, 3)), 2'(a), bus.id};
      bus.rtr_write_enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.rtr_write_enable = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.rx_addr = 2'(k); #1;
      vectors++;
      if ({bus.flag_res, bus.data_out} !== model_view(k % DEPTH)) begin
        $display("FAIL comb_sweep addr%0d got %b want %b", k % DEPTH,
                 {bus.flag_res, bus.data_out}, model_view(k % DEPTH));
        miscompares++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      bus.id = 2'($urandom_range(0, 3));
      bus.rx_in = 6'($urandom);
      if ($urandom_range(0, 1) == 1) bus.rx_in[1:0] = bus.id;
      bus.rtr_write_enable = ($urandom_range(0, 3) != 0);
      bus.rx_addr = ($urandom_range(0, 1) == 1) ? bus.rx_in[3:2] : 2'($urandom);
      #1;
      vectors++;
      if ({bus.flag_res, bus.data_out} !== model_view(int'(bus.rx_addr))) begin
        $display("FAIL rand_pre cyc%0d addr%0d got %b want %b", c, bus.rx_addr,
                 {bus.flag_res, bus.data_out}, model_view(int'(bus.rx_addr)));
        miscompares++;
      end
      tick();
      vectors++;
      if ({bus.flag_res, bus.data_out} !== model_view(int'(bus.rx_addr))) begin
        $display("FAIL rand_post cyc%0d addr%0d got %b want %b", c, bus.rx_addr,
                 {bus.flag_res, bus.data_out}, model_view(int'(bus.rx_addr)));
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_accept();
    test_mismatch();
    test_back_to_back();
    test_async_reset();
    test_comb_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
